pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 131 +++++++++++++
 tb/tb_pc_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter unit: sequential advance, branch/jump/call/ret redirects,
// a circular return-address stack and a RUN/HALTED control state machine.
module pc_unit #(
  parameter int unsigned           PC_WIDTH     = 32,
  parameter int unsigned           STEP         = 4,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int unsigned           RAS_DEPTH    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                halt_req,
  input  logic                resume,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic                call,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus_step,
  output logic                halted,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_ovf,
  output logic                ras_unf
);

  localparam int unsigned AW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [AW-1:0]         wp_q, wp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_en;
  logic [AW-1:0]         top_idx;
  logic [PC_WIDTH-1:0]   ras_q [RAS_DEPTH];

  assign pc_plus_step = pc_q + PC_WIDTH'(STEP);
  assign top_idx      = wp_q - AW'(1);
  assign ras_empty    = (cnt_q == '0);
  assign ras_full     = (cnt_q == CW'(RAS_DEPTH));

  // State register and control/pointer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      wp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage; entries are only meaningful below cnt_q, so no reset needed
  always_ff @(posedge clock) begin
    if (push_en) begin
      ras_q[wp_q] <= pc_plus_step;
    end
  end

  // Next-state and redirect selection: ret > call > jump > branch > step
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (!stall) begin
          if (ret) begin
            if (!ras_empty) begin
              pc_d  = ras_q[top_idx];
              wp_d  = top_idx;
              cnt_d = cnt_q - CW'(1);
            end else begin
              pc_d  = pc_plus_step;
              unf_d = 1'b1;
            end
          end else if (call) begin
            // A full stack wraps the write pointer onto the oldest entry
            push_en = 1'b1;
            pc_d    = jump_target;
            wp_d    = wp_q + AW'(1);
            if (ras_full) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (jump) begin
            pc_d = jump_target;
          end else if (branch_taken) begin
            pc_d = branch_target;
          end else begin
            pc_d = pc_plus_step;
          end
        end
      end
      HALTED: begin
        if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign pc      = pc_q;
  assign halted  = (state_q == HALTED);
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with default parameters (32-bit PC, STEP 4, 4-deep stack).
module tb_pc_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        halt_req;
  logic        resume;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic        call;
  logic        ret;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic        halted;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;

  int tests = 0;
  int fails = 0;

  pc_unit dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .halt_req      (halt_req),
    .resume        (resume),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .jump_target   (jump_target),
    .pc            (pc),
    .pc_plus_step  (pc_plus_step),
    .halted        (halted),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_ovf       (ras_ovf),
    .ras_unf       (ras_unf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic e, input logic f,
                           input logic o, input logic u);
    chk({tag, ".empty"}, 32'(ras_empty), 32'(e));
    chk({tag, ".full"},  32'(ras_full),  32'(f));
    chk({tag, ".ovf"},   32'(ras_ovf),   32'(o));
    chk({tag, ".unf"},   32'(ras_unf),   32'(u));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; call = 1'b0;
    ret = 1'b0; jump_target = '0;

    // Reset state and sequential advance
    step(); step();
    chk("rst.pc", pc, 32'h0);
    chk("rst.halted", 32'(halted), 32'h0);
    chk("rst.pps", pc_plus_step, 32'h4);
    chk_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(); chk("seq.1", pc, 32'h4);
    step(); chk("seq.2", pc, 32'h8);
    step(); chk("seq.3", pc, 32'hC);
    #2 reset = 1'b1;
    #1 chk("async_rst.pc", pc, 32'h0);
    reset = 1'b0;
    step(); chk("post_rst.pc", pc, 32'h4);

    // Call then return
    jump = 1'b1; jump_target = 32'h100;
    step(); chk("jmp.pc", pc, 32'h100);
    jump = 1'b0; call = 1'b1; jump_target = 32'h400;
    step(); chk("call.pc", pc, 32'h400);
    chk("call.empty", 32'(ras_empty), 32'h0);
    call = 1'b0; ret = 1'b1;
    step(); chk("ret.pc", pc, 32'h104);
    chk("ret.empty", 32'(ras_empty), 32'h1);
    // call and ret together on empty stack: ret wins, underflow, no push
    call = 1'b1;
    step(); chk("callret.pc", pc, 32'h108);
    chk_flags("callret", 1'b1, 1'b0, 1'b0, 1'b1);
    call = 1'b0; ret = 1'b0;

    // Stack overflow and underflow
    do_reset();
    call = 1'b1;
    jump_target = 32'h100; step(); chk("c1.pc", pc, 32'h100);
    jump_target = 32'h200; step();
    jump_target = 32'h300; step();
    jump_target = 32'h400; step(); chk_flags("c4", 1'b0, 1'b1, 1'b0, 1'b0);
    jump_target = 32'h500; step(); chk("c5.pc", pc, 32'h500);
    chk_flags("c5", 1'b0, 1'b1, 1'b1, 1'b0);
    call = 1'b0; ret = 1'b1;
    step(); chk("r1.pc", pc, 32'h404);
    chk("r1.full", 32'(ras_full), 32'h0);
    step(); chk("r2.pc", pc, 32'h304);
    step(); chk("r3.pc", pc, 32'h204);
    step(); chk("r4.pc", pc, 32'h104);
    chk("r4.empty", 32'(ras_empty), 32'h1);
    step(); chk("r5.pc", pc, 32'h108);
    chk_flags("r5", 1'b1, 1'b0, 1'b1, 1'b1);
    ret = 1'b0;

    // Stall and redirect priority
    do_reset();
    jump = 1'b1; jump_target = 32'h20;
    step(); chk("j20.pc", pc, 32'h20);
    jump = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    step(); chk("stall.pc", pc, 32'h20);
    call = 1'b1;
    step(); chk("stall_call.pc", pc, 32'h20);
    chk("stall_call.empty", 32'(ras_empty), 32'h1);
    call = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    step(); chk("unstall.pc", pc, 32'h24);
    jump = 1'b1; jump_target = 32'h60; branch_taken = 1'b1;
    step(); chk("jmp_vs_br.pc", pc, 32'h60);
    jump = 1'b0;
    step(); chk("br.pc", pc, 32'h80);
    branch_taken = 1'b0;

    // Halt and resume
    jump = 1'b1; jump_target = 32'h10;
    step(); chk("j10.pc", pc, 32'h10);
    halt_req = 1'b1; jump_target = 32'h70;
    step(); chk("halt.pc", pc, 32'h10);
    chk("halt.halted", 32'(halted), 32'h1);
    halt_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halted.pc", pc, 32'h10);
      chk("halted.halted", 32'(halted), 32'h1);
    end
    jump = 1'b0; resume = 1'b1;
    step(); chk("resume.pc", pc, 32'h10);
    chk("resume.halted", 32'(halted), 32'h0);
    resume = 1'b0;
    step(); chk("resume.adv", pc, 32'h14);
    // Reset while halted
    halt_req = 1'b1;
    step(); chk("halt2.halted", 32'(halted), 32'h1);
    halt_req = 1'b0; reset = 1'b1;
    #1 chk("rst_halt.halted", 32'(halted), 32'h0);
    chk("rst_halt.pc", pc, 32'h0);
    reset = 1'b0;
    step(); chk("rst_halt.adv", pc, 32'h4);

    // Wrap at top of address space
    do_reset();
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step(); chk("top.pc", pc, 32'hFFFF_FFFC);
    chk("top.pps", pc_plus_step, 32'h0);
    jump = 1'b0;
    step(); chk("wrap.pc", pc, 32'h0);
    chk_flags("wrap", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
